// File: rtl/breadboard_sweep_ctrl.sv
// Steps a 4-input breadboard through all 16 input vectors, captures its 10 outputs
// after a settle interval, and folds every accepted result into a rotating signature.
module breadboard_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic [9:0]  f_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_index,
    output logic [9:0]  res_f,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig
);

    // Out-of-range settle lengths fall back to a single cycle.
    localparam int         SETTLE_EFF = ((SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15)) ? SETTLE_CYCLES : 1;
    localparam logic [3:0] CNT_LOAD   = 4'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        res_valid_q, res_valid_d;
    logic [3:0]  res_index_q, res_index_d;
    logic [9:0]  res_f_q, res_f_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] sig_q, sig_d;

    function automatic logic [15:0] sig_fold(input logic [15:0] s, input logic [9:0] f);
        return {s[14:0], s[15]} ^ {6'b000000, f};
    endfunction

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_index_d = res_index_q;
        res_f_d     = res_f_q;
        sig_d       = sig_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    sig_d   = 16'h0000;
                    idx_d   = 4'd0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    res_f_d     = f_in;
                    res_index_d = idx_q;
                    res_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (res_valid_q && res_ready) begin
                    sig_d       = sig_fold(sig_q, res_f_q);
                    res_valid_d = 1'b0;
                    if (idx_q != 4'd15) begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            res_valid_q <= 1'b0;
            res_index_q <= 4'd0;
            res_f_q     <= 10'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_f_q     <= res_f_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sig_q       <= sig_d;
        end
    end

    assign {w, x, y, z} = idx_q;
    assign res_valid    = res_valid_q;
    assign res_index    = res_index_q;
    assign res_f        = res_f_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sig          = sig_q;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Directed-sequence bench for breadboard_sweep_ctrl with a randomized breadboard
// truth table and a signature reference computed from the expected result list.
module tb_breadboard_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        w, x, y, z;
    logic [9:0]  f_in;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_index;
    logic [9:0]  res_f;
    logic        busy;
    logic        done;
    logic [15:0] sig;

    logic [9:0]  ftab [16];
    bit          loop_mode;
    int          n_checks;
    int          n_fail;

    breadboard_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .f_in      (f_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_index (res_index),
        .res_f     (res_f),
        .busy      (busy),
        .done      (done),
        .sig       (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The breadboard: a truth table lookup, or a loopback of the drive vector.
    assign f_in = loop_mode ? {6'b000000, w, x, y, z} : ftab[{w, x, y, z}];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] expf(input int n);
        if (loop_mode) return 10'(n);
        return ftab[n];
    endfunction

    // Signature expected after the first n results have been accepted.
    function automatic logic [15:0] model_sig(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s = ((s << 1) | (s >> 15)) & 32'hFFFF;
            s = s ^ int'(expf(i));
        end
        return 16'(s);
    endfunction

    function automatic logic [36:0] all_outputs();
        return {w, x, y, z, res_valid, res_index, res_f, busy, done, sig};
    endfunction

    task automatic run_sweep(input string name, input int stall_at, input int stall_len,
                             input int abort_at, input bit hold_start);
        int exp_idx;
        int busy_cyc;
        bit finished;
        exp_idx   = 0;
        busy_cyc  = 0;
        finished  = 1'b0;
        res_ready = 1'b1;
        start     = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        check({name, " busy_after_start"}, 64'(busy), 64'd1);
        check({name, " sig_cleared"}, 64'(sig), 64'd0);
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (done) begin
                finished = 1'b1;
                check({name, " busy_cycles"}, 64'(busy_cyc), 64'(48 + stall_len));
                check({name, " results"}, 64'(exp_idx), 64'd16);
                check({name, " sig_at_done"}, 64'(sig), 64'(model_sig(16)));
                check({name, " wxyz_at_done"}, 64'({w, x, y, z}), 64'd15);
                tick();
                check({name, " done_one_cycle"}, 64'(done), 64'd0);
                check({name, " idle_after_done"}, 64'(busy), 64'd0);
                check({name, " sig_held"}, 64'(sig), 64'(model_sig(16)));
                if (hold_start) begin
                    tick();
                    check({name, " restart"}, 64'({busy, w, x, y, z}), 64'h10);
                    start = 1'b0;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check({name, " abort_settle"}, 64'({busy, res_valid, done}), 64'd0);
                end
            end else begin
                if (busy) busy_cyc++;
                if (res_valid) begin
                    check({name, " res_index"}, 64'(res_index), 64'(exp_idx));
                    check({name, " res_f"}, 64'(res_f), 64'(expf(exp_idx)));
                    check({name, " wxyz"}, 64'({w, x, y, z}), 64'(exp_idx));
                    if (exp_idx == abort_at) begin
                        abort = 1'b1;
                        tick();
                        abort = 1'b0;
                        check({name, " abort_idle"}, 64'({busy, res_valid, done}), 64'd0);
                        check({name, " abort_sig"}, 64'(sig), 64'(model_sig(abort_at)));
                        tick();
                        tick();
                        check({name, " abort_no_done"}, 64'({busy, done}), 64'd0);
                        check({name, " abort_wxyz_hold"}, 64'({w, x, y, z}), 64'(abort_at));
                        finished = 1'b1;
                    end else begin
                        if (exp_idx == stall_at) begin
                            res_ready = 1'b0;
                            for (int k = 0; k < stall_len; k++) begin
                                tick();
                                if (busy) busy_cyc++;
                                check({name, " stall_hold"},
                                      64'({res_valid, res_index, res_f, w, x, y, z}),
                                      64'({1'b1, 4'(exp_idx), expf(exp_idx), 4'(exp_idx)}));
                            end
                            res_ready = 1'b1;
                        end
                        exp_idx++;
                    end
                end
                if (!finished) tick();
            end
        end
        if (!finished) check({name, " timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        loop_mode = 1'b0;
        for (int i = 0; i < 16; i++) ftab[i] = 10'h3FF;

        #2 rst_n = 1'b0;
        #1 check("reset_async", 64'(all_outputs()), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_idle", 64'(all_outputs()), 64'd0);

        abort = 1'b1;
        tick();
        check("abort_in_idle", 64'(busy), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);
        tick();

        run_sweep("all_ones", -1, 0, -1, 1'b0);
        run_sweep("stall7", 7, 5, -1, 1'b0);

        loop_mode = 1'b1;
        run_sweep("loopback", -1, 0, -1, 1'b0);
        loop_mode = 1'b0;

        for (int i = 0; i < 16; i++) ftab[i] = 10'($urandom);
        run_sweep("random", 3, 2, -1, 1'b0);

        for (int i = 0; i < 16; i++) ftab[i] = 10'($urandom);
        run_sweep("abort4", -1, 0, 4, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1 check("reset_mid_settle", 64'(all_outputs()), 64'd0);
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", 64'(busy), 64'd0);
        tick();
        for (int i = 0; i < 16; i++) ftab[i] = 10'($urandom);
        run_sweep("post_reset", -1, 0, -1, 1'b0);

        for (int i = 0; i < 16; i++) ftab[i] = 10'($urandom);
        run_sweep("hold_start", -1, 0, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
